// File: rtl/com_uart_frame_rx.sv
// Frame de-packetiser behind a UART receiver: SOF, LEN, payload, XOR checksum.
// The payload is buffered and streamed out on valid/ready only after the checksum passes.
module com_uart_frame_rx #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned MAX_PAYLOAD    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ERR_CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_byte_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_parity_ok,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     rx_dropped
);

    localparam int unsigned PW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]    MaxLen  = 9'(MAX_PAYLOAD);

    localparam logic [1:0] ErrParity = 2'd0;
    localparam logic [1:0] ErrLen    = 2'd1;
    localparam logic [1:0] ErrChk    = 2'd2;
    localparam logic [1:0] ErrTmo    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StChk,
        StDrain
    } state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            len_m1_q, len_m1_d;
    logic [7:0]               chk_q, chk_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     frame_ok_q, frame_ok_d;
    logic                     frame_err_q, frame_err_d;
    logic [1:0]               err_code_q, err_code_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     rx_dropped_q, rx_dropped_d;

    logic [7:0]    mem_q [1 << PW];
    logic          mem_we;
    logic          abort;
    logic [1:0]    abort_code;
    logic [PW-1:0] rd_next;
    logic          len_legal;

    assign rd_next   = rd_ptr_q + PW'(1);
    assign len_legal = (rx_byte != 8'd0) && ({1'b0, rx_byte} <= MaxLen);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_m1_d     = len_m1_q;
        chk_d        = chk_q;
        tmo_d        = tmo_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        err_count_d  = err_count_q;
        rx_dropped_d = 1'b0;
        mem_we       = 1'b0;
        abort        = 1'b0;
        abort_code   = ErrParity;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (rx_byte_valid && rx_parity_ok && (rx_byte == SOF_BYTE)) begin
                    state_d = StLen;
                end
            end

            StLen, StPayload, StChk: begin
                if (rx_byte_valid) begin
                    tmo_d = '0;
                    if (!rx_parity_ok) begin
                        abort      = 1'b1;
                        abort_code = ErrParity;
                    end else if (state_q == StLen) begin
                        if (len_legal) begin
                            state_d  = StPayload;
                            chk_d    = rx_byte;
                            wr_ptr_d = '0;
                            len_m1_d = PW'(rx_byte - 8'd1);
                        end else begin
                            abort      = 1'b1;
                            abort_code = ErrLen;
                        end
                    end else if (state_q == StPayload) begin
                        mem_we   = 1'b1;
                        chk_d    = chk_q ^ rx_byte;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (wr_ptr_q == len_m1_q) begin
                            state_d = StChk;
                        end
                    end else if (rx_byte == chk_q) begin
                        // Present the first byte on the edge that accepts the checksum.
                        state_d     = StDrain;
                        frame_ok_d  = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = mem_q[0];
                        out_last_d  = (len_m1_q == '0);
                        rd_ptr_d    = '0;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ErrChk;
                    end
                end else if (tmo_q == TmoLast) begin
                    abort      = 1'b1;
                    abort_code = ErrTmo;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            StDrain: begin
                rx_dropped_d = rx_byte_valid;
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_ptr_d    = '0;
                    end else begin
                        rd_ptr_d   = rd_next;
                        out_data_d = mem_q[rd_next];
                        out_last_d = (rd_next == len_m1_q);
                    end
                end
            end

            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        if (abort) begin
            state_d     = StIdle;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = abort_code;
            if (err_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
                err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_m1_q     <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            err_count_q  <= '0;
            rx_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_m1_q     <= len_m1_d;
            chk_q        <= chk_d;
            tmo_q        <= tmo_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            err_count_q  <= err_count_d;
            rx_dropped_q <= rx_dropped_d;
        end
    end

    // Payload storage needs no reset; it is only read after a full frame is written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;
    assign rx_dropped = rx_dropped_q;

endmodule
